// File: rtl/i2c_write_multi_if.sv
// i2c_write_multi_if: link between the register-write sequencer and the shared I2C master.
//   master modport (sequencer): drives dev_address, the cmd stream (start/write_multiple/stop/valid),
//     the data_out stream (data/valid/last) and control; samples cmd_ready, data_out_ready,
//     bus_busy, bus_control, bus_active, missed_ack and relinquish.
//   slave modport (I2C master side): the mirror image.
interface i2c_write_multi_if;
    logic [6:0] dev_address;
    logic       cmd_start;
    logic       cmd_write_multiple;
    logic       cmd_stop;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready;
    logic       data_out_last;
    logic       bus_busy;
    logic       bus_control;
    logic       bus_active;
    logic       missed_ack;
    logic       control;
    logic       relinquish;

    modport master (
        output dev_address, cmd_start, cmd_write_multiple, cmd_stop, cmd_valid,
               data_out, data_out_valid, data_out_last, control,
        input  cmd_ready, data_out_ready, bus_busy, bus_control, bus_active,
               missed_ack, relinquish
    );

    modport slave (
        input  dev_address, cmd_start, cmd_write_multiple, cmd_stop, cmd_valid,
               data_out, data_out_valid, data_out_last, control,
        output cmd_ready, data_out_ready, bus_busy, bus_control, bus_active,
               missed_ack, relinquish
    );
endinterface

// File: rtl/i2c_write_multi.sv
// i2c_write_multi: writes a 1/2-byte register address plus 1..MAX_DATA_BYTES data bytes to a
// 7-bit I2C device in one START..STOP transaction, retrying on NACK and bounding waits with a timer.
//   clk, reset       : clock, synchronous active-high reset
//   start, dev_address, reg_address, data, data_len : request (accepted only when idle)
//   busy, done, message_failure, retries_used, state_out : status (all registered)
//   timer_start, timer_param, timer_exp : shared wait timer
//   i2c              : master modport toward the shared I2C master
module i2c_write_multi #(
    parameter int         REG_ADDR_BYTES = 1,
    parameter int         MAX_DATA_BYTES = 4,
    parameter int         MAX_RETRIES    = 2,
    parameter logic [3:0] TIMER_SEL      = 4'd1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [6:0]                  dev_address,
    input  logic [15:0]                 reg_address,
    input  logic [8*MAX_DATA_BYTES-1:0] data,
    input  logic [3:0]                  data_len,
    output logic                        busy,
    output logic                        done,
    output logic                        message_failure,
    output logic [3:0]                  retries_used,
    output logic                        timer_start,
    input  logic                        timer_exp,
    output logic [3:0]                  timer_param,
    output logic [3:0]                  state_out,
    i2c_write_multi_if.master           i2c
);
    typedef enum logic [3:0] {
        IDLE = 4'd0, WAIT_BUS = 4'd1, CMD = 4'd2, BYTE = 4'd3,
        WAIT_FREE = 4'd4, RETRY = 4'd5, FINISH = 4'd6
    } state_t;

    localparam logic [3:0] MAX_LEN = 4'(MAX_DATA_BYTES);
    localparam logic [3:0] MAX_RTY = 4'(MAX_RETRIES);
    localparam logic [4:0] ADDR_N  = 5'(REG_ADDR_BYTES);

    state_t                    state, state_n;
    logic [4:0]                k, k_n, last_idx;
    logic [3:0]                retries_n, len_q, len_n;
    logic [6:0]                dev_q, dev_n;
    logic [15:0]               reg_q, reg_n;
    logic [8*MAX_DATA_BYTES-1:0] data_q, data_n;
    logic [7:0]                byte_q, byte_n;
    logic                      last_q, last_n, done_n, fail_n;
    logic                      cmd_q, dv_q, waiting, waiting_n, free;

    // Byte i of the frame: register address MSB first, then payload bytes LSB first.
    function automatic logic [7:0] byte_at(input logic [4:0] i, input logic [15:0] r,
                                           input logic [8*MAX_DATA_BYTES-1:0] d);
        return (i < ADDR_N) ? 8'(r >> (8 * (REG_ADDR_BYTES - 1 - int'(i))))
                            : 8'(d >> (8 * (int'(i) - REG_ADDR_BYTES)));
    endfunction

    assign last_idx  = ADDR_N + {1'b0, len_q} - 5'd1;
    assign waiting   = state inside {WAIT_BUS, CMD, BYTE, WAIT_FREE, RETRY};
    assign waiting_n = state_n inside {WAIT_BUS, CMD, BYTE, WAIT_FREE, RETRY};
    assign free      = ~i2c.bus_busy & ~i2c.bus_control;

    always_comb begin
        state_n   = state;
        k_n       = k;
        retries_n = retries_used;
        len_n     = len_q;
        dev_n     = dev_q;
        reg_n     = reg_q;
        data_n    = data_q;
        byte_n    = byte_q;
        last_n    = last_q;
        done_n    = 1'b0;
        fail_n    = 1'b0;
        if (i2c.relinquish) begin
            state_n = IDLE;
        end else if (state != IDLE && i2c.missed_ack) begin
            fail_n    = retries_used >= MAX_RTY;
            state_n   = fail_n ? IDLE : RETRY;
            retries_n = fail_n ? retries_used : retries_used + 4'd1;
        end else if (waiting && timer_exp) begin
            fail_n  = 1'b1;
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: if (start) begin
                    dev_n     = dev_address;
                    reg_n     = reg_address;
                    data_n    = data;
                    len_n     = data_len;
                    retries_n = 4'd0;
                    fail_n    = (data_len == 4'd0) || (data_len > MAX_LEN);
                    state_n   = fail_n ? IDLE : WAIT_BUS;
                end
                WAIT_BUS: if (!i2c.bus_busy && !i2c.bus_active) state_n = CMD;
                CMD: if (i2c.cmd_ready) begin
                    state_n = BYTE;
                    k_n     = 5'd0;
                    byte_n  = byte_at(5'd0, reg_q, data_q);
                    last_n  = last_idx == 5'd0;
                end
                BYTE: if (i2c.data_out_ready) begin
                    if (k == last_idx) begin
                        state_n = WAIT_FREE;
                    end else begin
                        k_n    = k + 5'd1;
                        byte_n = byte_at(k + 5'd1, reg_q, data_q);
                        last_n = (k + 5'd1) == last_idx;
                    end
                end
                WAIT_FREE: if (free) state_n = FINISH;
                RETRY: if (free) begin
                    state_n = WAIT_BUS;
                    k_n     = 5'd0;
                end
                FINISH: begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
        if (state_n != BYTE) begin
            byte_n = 8'd0;
            last_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            k               <= 5'd0;
            retries_used    <= 4'd0;
            len_q           <= 4'd0;
            dev_q           <= 7'd0;
            reg_q           <= 16'd0;
            data_q          <= '0;
            byte_q          <= 8'd0;
            last_q          <= 1'b0;
            cmd_q           <= 1'b0;
            dv_q            <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            message_failure <= 1'b0;
            timer_start     <= 1'b0;
            timer_param     <= TIMER_SEL;
        end else begin
            state           <= state_n;
            k               <= k_n;
            retries_used    <= retries_n;
            len_q           <= len_n;
            dev_q           <= dev_n;
            reg_q           <= reg_n;
            data_q          <= data_n;
            byte_q          <= byte_n;
            last_q          <= last_n;
            cmd_q           <= state_n == CMD;
            dv_q            <= state_n == BYTE;
            busy            <= state_n != IDLE;
            done            <= done_n;
            message_failure <= fail_n;
            // Low for one cycle on each state change so the timer restarts per wait.
            timer_start     <= waiting_n && (state_n == state);
            timer_param     <= TIMER_SEL;
        end
    end

    assign state_out              = state;
    assign i2c.dev_address        = dev_q;
    assign i2c.cmd_start          = cmd_q;
    assign i2c.cmd_write_multiple = cmd_q;
    assign i2c.cmd_stop           = cmd_q;
    assign i2c.cmd_valid          = cmd_q;
    assign i2c.data_out           = byte_q;
    assign i2c.data_out_valid     = dv_q;
    assign i2c.data_out_last      = last_q;
    assign i2c.control            = busy;
endmodule

// File: tb/tb_i2c_write_multi.sv
// tb_i2c_write_multi: scenario bench for i2c_write_multi with a 1-byte-address instance (d1)
// and a 2-byte-address instance (d2); accepted bytes are logged and matched against an
// expected-byte queue filled when each request is issued.
module tb_i2c_write_multi;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start1 = 1'b0, start2 = 1'b0;
    logic [6:0]  dev = 7'd0;
    logic [15:0] rega = 16'd0;
    logic [31:0] data = 32'd0;
    logic [3:0]  len = 4'd0;
    logic        timer_exp = 1'b0;
    logic        busy1, done1, fail1, ts1, busy2, done2, fail2, ts2;
    logic [3:0]  ret1, tp1, so1, ret2, tp2, so2;

    int total = 0, bad = 0;
    int rd1 = 0, rd2 = 0;
    int cmd1 = 0, done1_n = 0, fail1_n = 0, done2_n = 0, fail2_n = 0;
    logic [8:0] got1_q[$], got2_q[$], exp1_q[$], exp2_q[$];

    i2c_write_multi_if i1();
    i2c_write_multi_if i2();

    always #5 clk = ~clk;

    i2c_write_multi #(.REG_ADDR_BYTES(1), .MAX_DATA_BYTES(4), .MAX_RETRIES(2), .TIMER_SEL(4'd1)) d1 (
        .clk(clk), .reset(reset), .start(start1), .dev_address(dev), .reg_address(rega),
        .data(data), .data_len(len), .busy(busy1), .done(done1), .message_failure(fail1),
        .retries_used(ret1), .timer_start(ts1), .timer_exp(timer_exp), .timer_param(tp1),
        .state_out(so1), .i2c(i1));

    i2c_write_multi #(.REG_ADDR_BYTES(2), .MAX_DATA_BYTES(4), .MAX_RETRIES(2), .TIMER_SEL(4'd1)) d2 (
        .clk(clk), .reset(reset), .start(start2), .dev_address(dev), .reg_address(rega),
        .data(data), .data_len(len), .busy(busy2), .done(done2), .message_failure(fail2),
        .retries_used(ret2), .timer_start(ts2), .timer_exp(timer_exp), .timer_param(tp2),
        .state_out(so2), .i2c(i2));

    always @(negedge clk) begin
        if (i1.data_out_valid && i1.data_out_ready) got1_q.push_back({i1.data_out_last, i1.data_out});
        if (i2.data_out_valid && i2.data_out_ready) got2_q.push_back({i2.data_out_last, i2.data_out});
        if (i1.cmd_valid && i1.cmd_ready) cmd1++;
        if (done1) done1_n++;
        if (fail1) fail1_n++;
        if (done2) done2_n++;
        if (fail2) fail2_n++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic go1(input logic [6:0] d, input logic [15:0] r, input logic [31:0] v, input logic [3:0] l);
        dev = d; rega = r; data = v; len = l; start1 = 1'b1;
        tick;
        start1 = 1'b0;
    endtask

    task automatic wait_idle1(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!busy1) begin
                ok = 1'b1;
                break;
            end
            tick;
        end
        tick;
    endtask

    task automatic test_reset;
        tick; tick;
        total++; if ({busy1, done1, fail1, ts1} !== 4'b0) begin bad++; $display("FAIL reset_status got=%b exp=0000", {busy1, done1, fail1, ts1}); end
        total++; if (ret1 !== 4'd0 || so1 !== 4'd0) begin bad++; $display("FAIL reset_ret_state got=%h/%h exp=0/0", ret1, so1); end
        total++; if (tp1 !== 4'd1 || tp2 !== 4'd1) begin bad++; $display("FAIL reset_timer_param got=%h/%h exp=1/1", tp1, tp2); end
        total++; if ({i1.control, i1.cmd_valid, i1.data_out_valid, i1.data_out_last} !== 4'b0) begin bad++; $display("FAIL reset_i2c got=%b exp=0000", {i1.control, i1.cmd_valid, i1.data_out_valid, i1.data_out_last}); end
        reset = 1'b0;
        tick;
    endtask

    task automatic test_single;
        bit ok; int c0, d0, f0; logic [8:0] e;
        c0 = cmd1; d0 = done1_n; f0 = fail1_n;
        exp1_q.push_back(9'h03A); exp1_q.push_back(9'h0EF); exp1_q.push_back(9'h1BE);
        go1(7'h21, 16'h003A, 32'h0000BEEF, 4'd2);
        total++; if (i1.control !== 1'b1 || i1.cmd_valid !== 1'b0) begin bad++; $display("FAIL single_control got=%b%b exp=10", i1.control, i1.cmd_valid); end
        tick;
        total++; if (i1.cmd_valid !== 1'b1 || i1.dev_address !== 7'h21 || {i1.cmd_start, i1.cmd_write_multiple, i1.cmd_stop} !== 3'b111) begin bad++; $display("FAIL single_cmd got=%b dev=%h exp=1 dev=21", i1.cmd_valid, i1.dev_address); end
        tick;
        total++; if (i1.data_out_valid !== 1'b1 || i1.data_out !== 8'h3A) begin bad++; $display("FAIL single_first_byte got=%b/%h exp=1/3a", i1.data_out_valid, i1.data_out); end
        wait_idle1(ok);
        total++; if (!ok) begin bad++; $display("FAIL single_timeout got=busy exp=idle"); end
        total++; if (cmd1 - c0 != 1 || done1_n - d0 != 1 || fail1_n - f0 != 0) begin bad++; $display("FAIL single_counts got=%0d/%0d/%0d exp=1/1/0", cmd1 - c0, done1_n - d0, fail1_n - f0); end
        total++; if (ret1 !== 4'd0) begin bad++; $display("FAIL single_retries got=%0d exp=0", ret1); end
        while (exp1_q.size() > 0) begin
            e = exp1_q.pop_front(); total++;
            if (rd1 >= got1_q.size()) begin bad++; $display("FAIL single_byte got=none exp=%h", e); end
            else begin
                if (got1_q[rd1] !== e) begin bad++; $display("FAIL single_byte got=%h exp=%h", got1_q[rd1], e); end
                rd1++;
            end
        end
        total++; if (got1_q.size() != rd1) begin bad++; $display("FAIL single_extra got=%0d exp=%0d", got1_q.size(), rd1); rd1 = got1_q.size(); end
    endtask

    task automatic test_ready_toggle;
        bit hv; logic [7:0] hb; int d0; logic [8:0] e;
        d0 = done2_n; hv = 1'b0; hb = 8'd0;
        exp2_q.push_back(9'h012); exp2_q.push_back(9'h034); exp2_q.push_back(9'h156);
        dev = 7'h10; rega = 16'h1234; data = 32'h00000056; len = 4'd1; start2 = 1'b1;
        tick;
        start2 = 1'b0;
        for (int i = 0; i < 80 && busy2; i++) begin
            if (hv) begin
                total++; if (i2.data_out_valid !== 1'b1 || i2.data_out !== hb) begin bad++; $display("FAIL toggle_hold got=%b/%h exp=1/%h", i2.data_out_valid, i2.data_out, hb); end
            end
            i2.data_out_ready = ~i2.data_out_ready;
            hv = i2.data_out_valid && !i2.data_out_ready;
            hb = i2.data_out;
            tick;
        end
        i2.data_out_ready = 1'b1;
        total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL toggle_timeout got=busy exp=idle"); end
        tick;
        total++; if (done2_n - d0 != 1) begin bad++; $display("FAIL toggle_done got=%0d exp=1", done2_n - d0); end
        while (exp2_q.size() > 0) begin
            e = exp2_q.pop_front(); total++;
            if (rd2 >= got2_q.size()) begin bad++; $display("FAIL toggle_byte got=none exp=%h", e); end
            else begin
                if (got2_q[rd2] !== e) begin bad++; $display("FAIL toggle_byte got=%h exp=%h", got2_q[rd2], e); end
                rd2++;
            end
        end
        total++; if (got2_q.size() != rd2) begin bad++; $display("FAIL toggle_extra got=%0d exp=%0d", got2_q.size(), rd2); rd2 = got2_q.size(); end
    endtask

    task automatic test_retry_once;
        bit ok; int c0, d0, f0; logic [8:0] e;
        c0 = cmd1; d0 = done1_n; f0 = fail1_n; ok = 1'b0;
        exp1_q.push_back(9'h03A);
        exp1_q.push_back(9'h03A); exp1_q.push_back(9'h0EF); exp1_q.push_back(9'h1BE);
        go1(7'h21, 16'h003A, 32'h0000BEEF, 4'd2);
        for (int i = 0; i < 30; i++) begin
            if (i1.data_out_valid && i1.data_out === 8'hEF) begin ok = 1'b1; break; end
            tick;
        end
        total++; if (!ok) begin bad++; $display("FAIL retry_reach_byte got=absent exp=ef"); end
        i1.data_out_ready = 1'b0; i1.missed_ack = 1'b1;
        tick;
        i1.data_out_ready = 1'b1; i1.missed_ack = 1'b0;
        total++; if (ret1 !== 4'd1 || i1.data_out_valid !== 1'b0 || so1 !== 4'd5) begin bad++; $display("FAIL retry_nack got=%0d/%b/%0d exp=1/0/5", ret1, i1.data_out_valid, so1); end
        wait_idle1(ok);
        total++; if (!ok) begin bad++; $display("FAIL retry_timeout got=busy exp=idle"); end
        total++; if (cmd1 - c0 != 2 || done1_n - d0 != 1 || fail1_n - f0 != 0 || ret1 !== 4'd1) begin bad++; $display("FAIL retry_counts got=%0d/%0d/%0d/%0d exp=2/1/0/1", cmd1 - c0, done1_n - d0, fail1_n - f0, ret1); end
        while (exp1_q.size() > 0) begin
            e = exp1_q.pop_front(); total++;
            if (rd1 >= got1_q.size()) begin bad++; $display("FAIL retry_byte got=none exp=%h", e); end
            else begin
                if (got1_q[rd1] !== e) begin bad++; $display("FAIL retry_byte got=%h exp=%h", got1_q[rd1], e); end
                rd1++;
            end
        end
        total++; if (got1_q.size() != rd1) begin bad++; $display("FAIL retry_extra got=%0d exp=%0d", got1_q.size(), rd1); rd1 = got1_q.size(); end
    endtask

    task automatic test_retry_exhaust;
        bit ok; int c0, d0, f0;
        c0 = cmd1; d0 = done1_n; f0 = fail1_n;
        go1(7'h21, 16'h003A, 32'h0000BEEF, 4'd2);
        for (int a = 0; a < 3; a++) begin
            ok = 1'b0;
            for (int i = 0; i < 30; i++) begin
                if (i1.data_out_valid) begin ok = 1'b1; break; end
                tick;
            end
            total++; if (!ok) begin bad++; $display("FAIL exhaust_attempt%0d got=no_byte exp=byte", a); end
            i1.data_out_ready = 1'b0; i1.missed_ack = 1'b1;
            tick;
            i1.data_out_ready = 1'b1; i1.missed_ack = 1'b0;
            if (a < 2) begin
                total++; if (ret1 !== 4'(a + 1)) begin bad++; $display("FAIL exhaust_retries got=%0d exp=%0d", ret1, a + 1); end
            end
        end
        total++; if (fail1 !== 1'b1 || so1 !== 4'd0 || i1.control !== 1'b0 || ret1 !== 4'd2) begin bad++; $display("FAIL exhaust_end got=%b/%0d/%b/%0d exp=1/0/0/2", fail1, so1, i1.control, ret1); end
        tick; tick;
        total++; if (cmd1 - c0 != 3 || done1_n - d0 != 0 || fail1_n - f0 != 1) begin bad++; $display("FAIL exhaust_counts got=%0d/%0d/%0d exp=3/0/1", cmd1 - c0, done1_n - d0, fail1_n - f0); end
        rd1 = got1_q.size();
    endtask

    task automatic test_timeout;
        int c0, f0;
        c0 = cmd1; f0 = fail1_n;
        i1.bus_busy = 1'b1;
        go1(7'h21, 16'h003A, 32'h0000BEEF, 4'd2);
        tick;
        total++; if (ts1 !== 1'b1 || tp1 !== 4'd1 || so1 !== 4'd1) begin bad++; $display("FAIL timeout_timer got=%b/%h/%0d exp=1/1/1", ts1, tp1, so1); end
        repeat (48) tick;
        timer_exp = 1'b1;
        tick;
        timer_exp = 1'b0;
        total++; if (fail1 !== 1'b1 || so1 !== 4'd0 || busy1 !== 1'b0) begin bad++; $display("FAIL timeout_abort got=%b/%0d/%b exp=1/0/0", fail1, so1, busy1); end
        tick;
        total++; if (cmd1 - c0 != 0 || fail1_n - f0 != 1) begin bad++; $display("FAIL timeout_counts got=%0d/%0d exp=0/1", cmd1 - c0, fail1_n - f0); end
        i1.bus_busy = 1'b0;
    endtask

    task automatic test_invalid;
        int c0, f0;
        c0 = cmd1; f0 = fail1_n;
        go1(7'h21, 16'h003A, 32'h0000BEEF, 4'd0);
        total++; if (fail1 !== 1'b1 || busy1 !== 1'b0 || i1.control !== 1'b0) begin bad++; $display("FAIL invalid_len0 got=%b/%b/%b exp=1/0/0", fail1, busy1, i1.control); end
        tick;
        total++; if (fail1 !== 1'b0) begin bad++; $display("FAIL invalid_pulse got=%b exp=0", fail1); end
        go1(7'h21, 16'h003A, 32'h0000BEEF, 4'd5);
        total++; if (fail1 !== 1'b1 || busy1 !== 1'b0 || i1.control !== 1'b0) begin bad++; $display("FAIL invalid_len5 got=%b/%b/%b exp=1/0/0", fail1, busy1, i1.control); end
        tick; tick;
        total++; if (cmd1 - c0 != 0 || fail1_n - f0 != 2) begin bad++; $display("FAIL invalid_counts got=%0d/%0d exp=0/2", cmd1 - c0, fail1_n - f0); end
    endtask

    task automatic test_relinquish;
        bit ok; int d0, f0; logic [8:0] e;
        d0 = done1_n; f0 = fail1_n; ok = 1'b0;
        exp1_q.push_back(9'h03A); exp1_q.push_back(9'h044);
        go1(7'h21, 16'h003A, 32'h11223344, 4'd4);
        for (int i = 0; i < 30; i++) begin
            if (i1.data_out_valid && i1.data_out === 8'h33) begin ok = 1'b1; break; end
            tick;
        end
        total++; if (!ok) begin bad++; $display("FAIL relinq_reach got=absent exp=33"); end
        i1.data_out_ready = 1'b0; i1.relinquish = 1'b1;
        tick;
        i1.data_out_ready = 1'b1; i1.relinquish = 1'b0;
        total++; if (so1 !== 4'd0 || busy1 !== 1'b0 || {i1.control, i1.cmd_valid, i1.data_out_valid} !== 3'b0) begin bad++; $display("FAIL relinq_idle got=%0d/%b/%b exp=0/0/000", so1, busy1, {i1.control, i1.cmd_valid, i1.data_out_valid}); end
        repeat (4) tick;
        total++; if (done1_n - d0 != 0 || fail1_n - f0 != 0) begin bad++; $display("FAIL relinq_pulses got=%0d/%0d exp=0/0", done1_n - d0, fail1_n - f0); end
        while (exp1_q.size() > 0) begin
            e = exp1_q.pop_front(); total++;
            if (rd1 >= got1_q.size()) begin bad++; $display("FAIL relinq_byte got=none exp=%h", e); end
            else begin
                if (got1_q[rd1] !== e) begin bad++; $display("FAIL relinq_byte got=%h exp=%h", got1_q[rd1], e); end
                rd1++;
            end
        end
        total++; if (got1_q.size() != rd1) begin bad++; $display("FAIL relinq_extra got=%0d exp=%0d", got1_q.size(), rd1); rd1 = got1_q.size(); end
    endtask

    task automatic test_back_to_back;
        bit ok1, ok2; int d0, f0; logic [8:0] e;
        d0 = done1_n; f0 = fail1_n;
        exp1_q.push_back(9'h03A); exp1_q.push_back(9'h15A);
        exp1_q.push_back(9'h03A); exp1_q.push_back(9'h1A5);
        go1(7'h21, 16'h003A, 32'h0000005A, 4'd1);
        tick;
        data = 32'd0; len = 4'd0; start1 = 1'b1;
        tick;
        start1 = 1'b0;
        wait_idle1(ok1);
        go1(7'h21, 16'h003A, 32'h000000A5, 4'd1);
        wait_idle1(ok2);
        total++; if (!ok1 || !ok2) begin bad++; $display("FAIL b2b_timeout got=%b%b exp=11", ok1, ok2); end
        total++; if (done1_n - d0 != 2 || fail1_n - f0 != 0) begin bad++; $display("FAIL b2b_counts got=%0d/%0d exp=2/0", done1_n - d0, fail1_n - f0); end
        while (exp1_q.size() > 0) begin
            e = exp1_q.pop_front(); total++;
            if (rd1 >= got1_q.size()) begin bad++; $display("FAIL b2b_byte got=none exp=%h", e); end
            else begin
                if (got1_q[rd1] !== e) begin bad++; $display("FAIL b2b_byte got=%h exp=%h", got1_q[rd1], e); end
                rd1++;
            end
        end
        total++; if (got1_q.size() != rd1) begin bad++; $display("FAIL b2b_extra got=%0d exp=%0d", got1_q.size(), rd1); rd1 = got1_q.size(); end
    endtask

    initial begin
        i1.cmd_ready = 1'b1; i1.data_out_ready = 1'b1; i1.bus_busy = 1'b0; i1.bus_control = 1'b0;
        i1.bus_active = 1'b0; i1.missed_ack = 1'b0; i1.relinquish = 1'b0;
        i2.cmd_ready = 1'b1; i2.data_out_ready = 1'b1; i2.bus_busy = 1'b0; i2.bus_control = 1'b0;
        i2.bus_active = 1'b0; i2.missed_ack = 1'b0; i2.relinquish = 1'b0;
        test_reset;
        test_single;
        test_ready_toggle;
        test_retry_once;
        test_retry_exhaust;
        test_timeout;
        test_invalid;
        test_relinquish;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
